// File: rtl/exception_sequencer.sv
// Exception/interrupt sequencer: irq sync+prioritise, pipeline flush, CP0 commit; EXC_IRQ_EDGE_EN selects edge-latched irqs.
// Latency: exc_req/busy 1 cycle after the event, CP0 commit 1 cycle after pipe_idle is sampled, ERET write 1 cycle after the event.
// Backpressure: holds in DRAIN while pipe_idle is low; new events are ignored while busy.
`ifndef MMU_EXCEPTION
`define MMU_EXCEPTION 5
`endif
`ifndef MMU_EXCEPTION_NONE
`define MMU_EXCEPTION_NONE 5'd0
`endif
`ifndef CPU_EXCEPTION_INT
`define CPU_EXCEPTION_INT 5'd0
`endif
`ifndef CPU_EXCEPTION_SYS
`define CPU_EXCEPTION_SYS 5'd8
`endif

module exception_sequencer #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic [NUM_IRQ-1:0]        irq,
  input  logic [`MMU_EXCEPTION-1:0] mmu_exception,
  input  logic                      syscall,
  input  logic                      eret,
  input  logic                      inst_valid,
  input  logic                      pipe_idle,
  input  logic [31:0]               cp0_status,
  input  logic [31:0]               cp0_cause,
  output logic                      exc_req,
  output logic                      incEpc,
  output logic                      busy,
  output logic                      we_status,
  output logic                      we_cause,
  output logic                      we_epc,
  output logic                      we_badVAddr,
  output logic [31:0]               out_status,
  output logic [31:0]               out_cause
);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, RETURN} state_t;

  state_t               state;
  logic [NUM_IRQ-1:0]   sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0]   sync_irq;
  logic [NUM_IRQ-1:0]   pend;
  logic [NUM_IRQ-1:0]   masked;
  logic                 int_ok;
  logic                 mmu_hit;
  logic                 exc_hit;
  logic [4:0]           code_q;
  logic                 inc_q;
  logic                 badv_q;
  logic                 exl_q;
  logic [7:0]           ip;
  logic                 unused_ok;

  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= irq;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_irq = sync_q[SYNC_STAGES-1];

`ifdef EXC_IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] sync_d;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] clr_q;

  // A new rising edge in the same cycle as the clear keeps the bit pending.
  always_ff @(posedge clk) begin
    if (res) begin
      sync_d <= '0;
      pend_q <= '0;
    end else begin
      sync_d <= sync_irq;
      pend_q <= (pend_q & ~((state == COMMIT) ? clr_q : '0)) | (sync_irq & ~sync_d);
    end
  end

  assign pend = pend_q;
`else
  assign pend = sync_irq;
`endif

  assign masked  = pend & cp0_status[8 +: NUM_IRQ];
  assign int_ok  = cp0_status[0] & ~cp0_status[1] & ~cp0_status[2] & (|masked);
  assign mmu_hit = (mmu_exception != `MMU_EXCEPTION_NONE);
  assign exc_hit = int_ok | mmu_hit | syscall;

  always_ff @(posedge clk) begin
    if (res) begin
      state       <= IDLE;
      code_q      <= '0;
      inc_q       <= 1'b0;
      badv_q      <= 1'b0;
      exl_q       <= 1'b0;
      exc_req     <= 1'b0;
      we_status   <= 1'b0;
      we_cause    <= 1'b0;
      we_epc      <= 1'b0;
      we_badVAddr <= 1'b0;
      incEpc      <= 1'b0;
`ifdef EXC_IRQ_EDGE_EN
      clr_q       <= '0;
`endif
    end else begin
      exc_req     <= 1'b0;
      we_status   <= 1'b0;
      we_cause    <= 1'b0;
      we_epc      <= 1'b0;
      we_badVAddr <= 1'b0;
      incEpc      <= 1'b0;
      case (state)
        IDLE: begin
          if (inst_valid && exc_hit) begin
            state   <= DRAIN;
            exc_req <= 1'b1;
            exl_q   <= cp0_status[1];
            if (int_ok) begin
              code_q <= `CPU_EXCEPTION_INT;
              inc_q  <= 1'b0;
              badv_q <= 1'b0;
            end else if (mmu_hit) begin
              code_q <= 5'(mmu_exception);
              inc_q  <= 1'b0;
              badv_q <= 1'b1;
            end else begin
              code_q <= `CPU_EXCEPTION_SYS;
              inc_q  <= 1'b1;
              badv_q <= 1'b0;
            end
`ifdef EXC_IRQ_EDGE_EN
            clr_q <= int_ok ? masked : '0;
`endif
          end else if (inst_valid && eret) begin
            state     <= RETURN;
            we_status <= 1'b1;
          end
        end
        DRAIN: begin
          if (pipe_idle) begin
            state       <= COMMIT;
            we_status   <= 1'b1;
            we_cause    <= 1'b1;
            we_epc      <= ~exl_q;
            we_badVAddr <= badv_q;
            incEpc      <= inc_q;
          end
        end
        COMMIT:  state <= IDLE;
        RETURN:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ip = '0;
    ip[NUM_IRQ-1:0] = pend;
    out_status = '0;
    out_cause  = '0;
    case (state)
      COMMIT: begin
        out_status = {cp0_status[31:2], 1'b1, cp0_status[0]};
        out_cause  = {cp0_cause[31:16], ip, 1'b0, code_q, 2'b00};
      end
      RETURN:  out_status = {cp0_status[31:2], 1'b0, cp0_status[0]};
      default: ;
    endcase
  end

  assign busy      = (state != IDLE);
  assign unused_ok = &{1'b0, cp0_cause[15:0]};

endmodule
